// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: one data-memory bus transaction per memory instruction.
// The unit aligns store data and byte mask onto the 8-byte bus word. It returns load data
// right-aligned and leaves sign/zero extension to the decode path.
module lsu_mem_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        ex_valid,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [7:0]  ex_width,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [63:0] load_data,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [7:0]  dmem_wmask,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       off_q;
    logic             err_q;
    logic             mem_op, accept, misaligned, handshake, expired;

    // Byte-lane mask shifted to the access offset within the bus word.
    function automatic logic [7:0] lane_mask(input logic [7:0] w, input logic [2:0] off);
        return w << off;
    endfunction

    // An access is misaligned when its shifted mask spills past the top lane.
    function automatic logic lane_overflow(input logic [7:0] w, input logic [2:0] off);
        logic [15:0] wide;
        wide = {8'h00, w} << off;
        return |wide[15:8];
    endfunction

    function automatic logic [63:0] align_store(input logic [63:0] d, input logic [2:0] off);
        return d << {off, 3'b000};
    endfunction

    // Upper bytes are zero-filled by the logical shift.
    function automatic logic [63:0] align_load(input logic [63:0] d, input logic [2:0] off);
        return d >> {off, 3'b000};
    endfunction

    assign mem_op     = ex_is_load | ex_is_store;
    assign accept     = ex_valid & mem_op;
    assign misaligned = lane_overflow(ex_width, ex_addr[2:0]);
    assign handshake  = dmem_req_valid & dmem_req_ready;
    // The counter value plus one is the number of REQ/WAIT_RSP cycles spent so far.
    assign expired    = cnt >= CNT_W'(TIMEOUT_CYCLES - 1);

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_nxt      = state;
        dmem_req_valid = 1'b0;
        lsu_done       = 1'b0;
        lsu_err        = 1'b0;
        lsu_stall      = 1'b0;
        case (state)
            IDLE: begin
                lsu_stall = accept;
                if (accept) state_nxt = misaligned ? DONE : REQ;
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                lsu_stall      = 1'b1;
                if (dmem_req_ready) state_nxt = dmem_we ? DONE : WAIT_RSP;
                else if (expired)   state_nxt = DONE;
            end
            WAIT_RSP: begin
                lsu_stall = 1'b1;
                if (dmem_rsp_valid || expired) state_nxt = DONE;
            end
            DONE: begin
                lsu_done  = 1'b1;
                lsu_err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, timeout counter and load-data alignment.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            cnt        <= '0;
            off_q      <= '0;
            err_q      <= 1'b0;
            load_data  <= '0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt        <= '0;
                        off_q      <= ex_addr[2:0];
                        err_q      <= misaligned;
                        load_data  <= '0;
                        dmem_we    <= ex_is_store;
                        dmem_addr  <= {ex_addr[63:3], 3'b000};
                        dmem_wmask <= lane_mask(ex_width, ex_addr[2:0]);
                        dmem_wdata <= align_store(ex_wdata, ex_addr[2:0]);
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (!handshake && expired) err_q <= 1'b1;
                end
                WAIT_RSP: begin
                    cnt <= cnt + 1'b1;
                    if (dmem_rsp_valid) begin
                        load_data <= align_load(dmem_rdata, off_q);
                    end else if (expired) begin
                        err_q     <= 1'b1;
                        load_data <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Randomized bench for lsu_mem_stage against a cycle-count reference model of the unit.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [7:0]  ex_width;
    logic [63:0] ex_addr, ex_wdata;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [63:0] load_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_rsp_valid;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .ex_valid       (ex_valid),
        .ex_is_load     (ex_is_load),
        .ex_is_store    (ex_is_store),
        .ex_width       (ex_width),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .lsu_stall      (lsu_stall),
        .lsu_done       (lsu_done),
        .lsu_err        (lsu_err),
        .load_data      (load_data),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wmask     (dmem_wmask),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One instruction: expected timing and results come from the rules of the unit
    // (latency per op type, timeout after TO active cycles, lane arithmetic).
    task automatic do_op(input bit ld, input bit st, input logic [7:0] w, input logic [63:0] a,
                         input logic [63:0] d, input int rdly, input int pdly, input logic [63:0] rd);
        bit          mem, mis, exp_err;
        int          off, exp_done, req_end, rsp_cyc, lim, last;
        logic [15:0] sh;
        logic [63:0] exp_ld, exp_wd;
        mem = ld | st;
        off = int'(a[2:0]);
        sh  = {8'h00, w} << off;
        mis = mem && (sh[15:8] != 8'h00);
        exp_wd   = d << (8 * off);
        exp_err  = 1'b0;
        exp_ld   = '0;
        exp_done = 0;
        req_end  = 0;
        rsp_cyc  = -1;
        if (!mem) begin
            exp_done = 0;
        end else if (mis) begin
            exp_done = 1;
            exp_err  = 1'b1;
        end else if (rdly >= TO) begin
            req_end  = TO;
            exp_done = TO + 1;
            exp_err  = 1'b1;
            rsp_cyc  = TO + 2;
        end else begin
            req_end = rdly + 1;
            if (st) begin
                exp_done = rdly + 2;
            end else begin
                rsp_cyc = rdly + 2 + pdly;
                lim     = (TO > rdly + 2) ? TO : rdly + 2;
                if (rsp_cyc <= lim) begin
                    exp_done = rsp_cyc + 1;
                    exp_ld   = rd >> (8 * off);
                end else begin
                    exp_done = lim + 1;
                    exp_err  = 1'b1;
                end
            end
        end
        last = (exp_done > rsp_cyc) ? exp_done : rsp_cyc;
        if (last < 3) last = 3;
        last = last + 1;

        @(negedge sys_clk);
        ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st;
        ex_width = w; ex_addr = a; ex_wdata = d;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = rnd64();
        #1;
        chk("stall_accept", lsu_stall, mem);
        chk("done_accept", lsu_done, 1'b0);
        chk("req_accept", dmem_req_valid, 1'b0);
        for (int c = 1; c <= last; c++) begin
            @(negedge sys_clk);
            ex_valid    = (c == exp_done) ? 1'b1 : ((c < exp_done) ? 1'($urandom_range(0, 1)) : 1'b0);
            ex_is_load  = 1'($urandom_range(0, 1));
            ex_is_store = (c == exp_done) ? 1'b1 : 1'($urandom_range(0, 1));
            ex_width    = 8'($urandom);
            ex_addr     = rnd64();
            ex_wdata    = rnd64();
            dmem_req_ready = (c >= rdly + 1);
            dmem_rsp_valid = (c == rsp_cyc) || ((c <= req_end) && ($urandom_range(0, 1) == 1));
            dmem_rdata     = (c == rsp_cyc) ? rd : rnd64();
            #1;
            chk("done", lsu_done, (c == exp_done));
            chk("stall", lsu_stall, (c < exp_done));
            chk("req_valid", dmem_req_valid, (c <= req_end));
            if (c <= req_end) begin
                chk("dmem_addr", dmem_addr, {a[63:3], 3'b000});
                chk("dmem_wmask", dmem_wmask, sh[7:0]);
                chk("dmem_wdata", dmem_wdata, exp_wd);
                chk("dmem_we", dmem_we, st);
            end
            if (c == exp_done) begin
                chk("err", lsu_err, exp_err);
                if (!st) chk("load_data", load_data, exp_ld);
            end
        end
        ex_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    endtask

    initial begin
        sys_rst_n = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
        ex_width = '0; ex_addr = '0; ex_wdata = '0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge sys_clk);
        #1;
        chk("rst_done", lsu_done, 1'b0);
        chk("rst_err", lsu_err, 1'b0);
        chk("rst_load_data", load_data, 64'h0);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 64'h0);
        chk("rst_wmask", dmem_wmask, 8'h00);
        chk("rst_wdata", dmem_wdata, 64'h0);
        chk("rst_stall", lsu_stall, 1'b0);
        sys_rst_n = 1'b1;

        // Directed cases
        do_op(1'b0, 1'b1, 8'hFF, 64'h1000, 64'hDEADBEEF_01234567, 0, 0, 64'h0);
        do_op(1'b0, 1'b1, 8'h01, 64'h1005, 64'h0000_0000_0000_00AB, 0, 0, 64'h0);
        do_op(1'b1, 1'b0, 8'h0F, 64'h2004, 64'h0, 0, 2, 64'h11223344_55667788);
        do_op(1'b1, 1'b0, 8'h03, 64'h2007, 64'h0, 0, 0, 64'h0);
        do_op(1'b0, 1'b1, 8'hFF, 64'h3000, 64'h55, 6, 0, 64'h0);
        do_op(1'b1, 1'b0, 8'hFF, 64'h3008, 64'h0, 6, 0, 64'h99);
        do_op(1'b1, 1'b0, 8'hFF, 64'h3010, 64'h0, 0, 5, 64'h77);
        do_op(1'b1, 1'b1, 8'h0F, 64'h4000, 64'hCAFEF00D, 0, 0, 64'h0);
        do_op(1'b0, 1'b0, 8'hFF, 64'h5000, 64'h0, 0, 0, 64'h0);

        // Reset taken while waiting for a load response
        @(negedge sys_clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_is_store = 1'b0;
        ex_width = 8'hFF; ex_addr = 64'h6000; dmem_req_ready = 1'b1;
        @(negedge sys_clk);
        ex_valid = 1'b0;
        #1 chk("rstmid_req", dmem_req_valid, 1'b1);
        @(negedge sys_clk);
        #1;
        chk("rstmid_wait_stall", lsu_stall, 1'b1);
        chk("rstmid_wait_req", dmem_req_valid, 1'b0);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        dmem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dmem_rsp_valid = (i < 2);
            dmem_rdata = rnd64();
            #1;
            chk("rstmid_done", lsu_done, 1'b0);
            chk("rstmid_stall", lsu_stall, 1'b0);
            chk("rstmid_req_valid", dmem_req_valid, 1'b0);
            @(negedge sys_clk);
        end
        dmem_rsp_valid = 1'b0;
        do_op(1'b0, 1'b1, 8'hFF, 64'h7000, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0);

        // Randomized operations
        for (int i = 0; i < 200; i++) begin
            bit          l, s;
            logic [7:0]  w;
            logic [63:0] a;
            int          k;
            k = int'($urandom_range(0, 3));
            w = (k == 0) ? 8'h01 : (k == 1) ? 8'h03 : (k == 2) ? 8'h0F : 8'hFF;
            l = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = rnd64();
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'b000;
            do_op(l, s, w, a, rnd64(), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), rnd64());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
